yutorina_id_stage: RTL and testbench

Instruction-decode stage of the Yutorina pipeline, directly downstream of the fetch stage. It takes the fetched `if_pc`/`if_insn`/`if_en_` and reads the general-purpose register file with EX/MEM forwarding. It decodes the instruction into ALU, memory and write-back controls, latched into the ID/EX pipeline register. It resolves branches in the same cycle and returns `br_taken`/`br_addr` to fetch, and flags load-use hazards to the pipeline controller.

---
 rtl/yutorina_id_stage_pkg.sv | 110 +++++++++++
 rtl/yutorina_id_stage_decoder.sv | 142 ++++++++++++++
 rtl/yutorina_id_stage.sv | 110 +++++++++++
 tb/tb_yutorina_id_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/yutorina_id_stage_pkg.sv
// Shared ISA encodings and the decoded control bundle for the Yutorina ID stage.
// Holds the opcode, ALU-op, mem-op and exception encodings and the forwarding mux.
// Ports: none (package).
package yutorina_id_stage_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;
  localparam int REG_ADDR_W  = 5;

  // Link register written by CALL.
  localparam logic [REG_ADDR_W-1:0] REG_LINK = 5'd31;

  localparam logic [5:0] OP_ANDR  = 6'h00;
  localparam logic [5:0] OP_ANDI  = 6'h01;
  localparam logic [5:0] OP_ORR   = 6'h02;
  localparam logic [5:0] OP_ORI   = 6'h03;
  localparam logic [5:0] OP_XORR  = 6'h04;
  localparam logic [5:0] OP_XORI  = 6'h05;
  localparam logic [5:0] OP_ADDSR = 6'h06;
  localparam logic [5:0] OP_ADDSI = 6'h07;
  localparam logic [5:0] OP_ADDUR = 6'h08;
  localparam logic [5:0] OP_ADDUI = 6'h09;
  localparam logic [5:0] OP_SUBSR = 6'h0A;
  localparam logic [5:0] OP_SUBUR = 6'h0B;
  localparam logic [5:0] OP_SHRLR = 6'h0C;
  localparam logic [5:0] OP_SHRLI = 6'h0D;
  localparam logic [5:0] OP_SHLLR = 6'h0E;
  localparam logic [5:0] OP_SHLLI = 6'h0F;
  localparam logic [5:0] OP_BE    = 6'h10;
  localparam logic [5:0] OP_BNE   = 6'h11;
  localparam logic [5:0] OP_BSGT  = 6'h12;
  localparam logic [5:0] OP_BUGT  = 6'h13;
  localparam logic [5:0] OP_JMP   = 6'h14;
  localparam logic [5:0] OP_CALL  = 6'h15;
  localparam logic [5:0] OP_LDW   = 6'h16;
  localparam logic [5:0] OP_STW   = 6'h17;
  localparam logic [5:0] OP_TRAP  = 6'h18;

  // ALU_NOP passes alu_in_0 through unchanged.
  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_AND  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_ADDS = 4'd4,
    ALU_ADDU = 4'd5,
    ALU_SUBS = 4'd6,
    ALU_SUBU = 4'd7,
    ALU_SHRL = 4'd8,
    ALU_SHLL = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_NOP = 2'd0,
    MEM_LDW = 2'd1,
    MEM_STW = 2'd2
  } mem_op_e;

  typedef enum logic [2:0] {
    EXP_NONE  = 3'd0,
    EXP_UNDEF = 3'd1,
    EXP_TRAP  = 3'd2
  } exp_code_e;

  typedef struct packed {
    alu_op_e                alu_op;
    logic [WORD_DATA_W-1:0] alu_in_0;
    logic [WORD_DATA_W-1:0] alu_in_1;
    logic                   br_flag;
    mem_op_e                mem_op;
    logic [WORD_DATA_W-1:0] mem_wr_data;
    logic [REG_ADDR_W-1:0]  dst_addr;
    logic                   gpr_we_;
    exp_code_e              exp_code;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{
    alu_op:      ALU_NOP,
    alu_in_0:    '0,
    alu_in_1:    '0,
    br_flag:     1'b0,
    mem_op:      MEM_NOP,
    mem_wr_data: '0,
    dst_addr:    '0,
    gpr_we_:     1'b1,
    exp_code:    EXP_NONE
  };

  // Operand source select: youngest in-flight producer wins, then the register file.
  function automatic logic [WORD_DATA_W-1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0]  addr,
    input logic                   ex_en_,
    input logic                   ex_we_,
    input logic [REG_ADDR_W-1:0]  ex_dst,
    input logic [WORD_DATA_W-1:0] ex_data,
    input logic                   mem_en_,
    input logic                   mem_we_,
    input logic [REG_ADDR_W-1:0]  mem_dst,
    input logic [WORD_DATA_W-1:0] mem_data,
    input logic [WORD_DATA_W-1:0] rf_data
  );
    if (!ex_en_ && !ex_we_ && (ex_dst == addr))
      return ex_data;
    else if (!mem_en_ && !mem_we_ && (mem_dst == addr))
      return mem_data;
    else
      return rf_data;
  endfunction

endpackage

// File: rtl/yutorina_id_stage_decoder.sv
// Combinational decode: field split, EX/MEM forwarding, branch resolve, load-use detect.
// Ports: instruction/pc in, register-file addresses/data, forwarding taps; ctrl bundle,
// br_taken/br_addr and ld_hazard out. Zero latency, no state.
module yutorina_decoder
  import yutorina_id_stage_pkg::*;
(
  input  logic [WORD_ADDR_W-1:0] if_pc,
  input  logic [WORD_DATA_W-1:0] if_insn,
  input  logic                   if_en_,
  output logic [REG_ADDR_W-1:0]  gpr_rd_addr_0,
  output logic [REG_ADDR_W-1:0]  gpr_rd_addr_1,
  input  logic [WORD_DATA_W-1:0] gpr_rd_data_0,
  input  logic [WORD_DATA_W-1:0] gpr_rd_data_1,
  input  logic                   ex_en_,
  input  logic                   ex_gpr_we_,
  input  logic [REG_ADDR_W-1:0]  ex_dst_addr,
  input  logic [WORD_DATA_W-1:0] ex_fwd_data,
  input  logic [1:0]             ex_mem_op,
  input  logic                   mem_en_,
  input  logic                   mem_gpr_we_,
  input  logic [REG_ADDR_W-1:0]  mem_dst_addr,
  input  logic [WORD_DATA_W-1:0] mem_fwd_data,
  output ctrl_t                  dec,
  output logic                   br_taken,
  output logic [WORD_ADDR_W-1:0] br_addr,
  output logic                   ld_hazard
);

  logic [5:0]             op;
  logic [REG_ADDR_W-1:0]  ra_addr, rb_addr;
  logic [15:0]            imm;
  logic [WORD_DATA_W-1:0] ra_data, rb_data, imm_s, imm_z;
  logic                   r_form, i_zext, i_sext, ra_used, rb_used, br_cond;

  assign op      = if_insn[31:26];
  assign ra_addr = if_insn[25:21];
  assign rb_addr = if_insn[20:16];
  assign imm     = if_insn[15:0];
  assign imm_s   = {{16{imm[15]}}, imm};
  assign imm_z   = {16'h0000, imm};

  assign gpr_rd_addr_0 = ra_addr;
  assign gpr_rd_addr_1 = rb_addr;

  assign ra_data = fwd_sel(ra_addr, ex_en_, ex_gpr_we_, ex_dst_addr, ex_fwd_data,
                           mem_en_, mem_gpr_we_, mem_dst_addr, mem_fwd_data, gpr_rd_data_0);
  assign rb_data = fwd_sel(rb_addr, ex_en_, ex_gpr_we_, ex_dst_addr, ex_fwd_data,
                           mem_en_, mem_gpr_we_, mem_dst_addr, mem_fwd_data, gpr_rd_data_1);

  always_comb begin
    dec          = CTRL_RST;
    dec.alu_in_0 = ra_data;
    dec.dst_addr = rb_addr;
    r_form       = 1'b0;
    i_zext       = 1'b0;
    i_sext       = 1'b0;
    ra_used      = 1'b0;
    rb_used      = 1'b0;
    br_cond      = 1'b0;
    // PC-relative target; the 30-bit add wraps naturally.
    br_addr      = if_pc + imm_s[WORD_ADDR_W-1:0];

    case (op)
      OP_ANDR:  begin dec.alu_op = ALU_AND;  r_form = 1'b1; end
      OP_ANDI:  begin dec.alu_op = ALU_AND;  i_zext = 1'b1; end
      OP_ORR:   begin dec.alu_op = ALU_OR;   r_form = 1'b1; end
      OP_ORI:   begin dec.alu_op = ALU_OR;   i_zext = 1'b1; end
      OP_XORR:  begin dec.alu_op = ALU_XOR;  r_form = 1'b1; end
      OP_XORI:  begin dec.alu_op = ALU_XOR;  i_zext = 1'b1; end
      OP_ADDSR: begin dec.alu_op = ALU_ADDS; r_form = 1'b1; end
      OP_ADDSI: begin dec.alu_op = ALU_ADDS; i_sext = 1'b1; end
      OP_ADDUR: begin dec.alu_op = ALU_ADDU; r_form = 1'b1; end
      OP_ADDUI: begin dec.alu_op = ALU_ADDU; i_zext = 1'b1; end
      OP_SUBSR: begin dec.alu_op = ALU_SUBS; r_form = 1'b1; end
      OP_SUBUR: begin dec.alu_op = ALU_SUBU; r_form = 1'b1; end
      OP_SHRLR: begin dec.alu_op = ALU_SHRL; r_form = 1'b1; end
      OP_SHRLI: begin dec.alu_op = ALU_SHRL; i_zext = 1'b1; end
      OP_SHLLR: begin dec.alu_op = ALU_SHLL; r_form = 1'b1; end
      OP_SHLLI: begin dec.alu_op = ALU_SHLL; i_zext = 1'b1; end
      OP_BE, OP_BNE, OP_BSGT, OP_BUGT: begin
        dec.br_flag  = 1'b1;
        dec.alu_in_1 = rb_data;
        ra_used      = 1'b1;
        rb_used      = 1'b1;
        case (op)
          OP_BE:   br_cond = (ra_data == rb_data);
          OP_BNE:  br_cond = (ra_data != rb_data);
          OP_BSGT: br_cond = ($signed(ra_data) > $signed(rb_data));
          default: br_cond = (ra_data > rb_data);
        endcase
      end
      OP_JMP, OP_CALL: begin
        dec.br_flag = 1'b1;
        ra_used     = 1'b1;
        br_cond     = 1'b1;
        br_addr     = ra_data[WORD_DATA_W-1:2];
        if (op == OP_CALL) begin
          // Return address rides through the ALU as a pass-through operand.
          dec.alu_in_0 = {if_pc, 2'b00};
          dec.dst_addr = REG_LINK;
          dec.gpr_we_  = 1'b0;
        end
      end
      OP_LDW, OP_STW: begin
        dec.alu_op   = ALU_ADDU;
        dec.alu_in_1 = imm_s;
        ra_used      = 1'b1;
        if (op == OP_LDW) begin
          dec.mem_op  = MEM_LDW;
          dec.gpr_we_ = 1'b0;
        end else begin
          dec.mem_op      = MEM_STW;
          dec.mem_wr_data = rb_data;
          rb_used         = 1'b1;
        end
      end
      OP_TRAP: dec.exp_code = EXP_TRAP;
      default: dec.exp_code = EXP_UNDEF;
    endcase

    if (r_form) begin
      dec.alu_in_1 = rb_data;
      dec.dst_addr = imm[15:11];
      dec.gpr_we_  = 1'b0;
      ra_used      = 1'b1;
      rb_used      = 1'b1;
    end
    if (i_zext || i_sext) begin
      dec.alu_in_1 = i_sext ? imm_s : imm_z;
      dec.gpr_we_  = 1'b0;
      ra_used      = 1'b1;
    end
  end

  // Only registers the instruction really reads can create a load-use hazard.
  assign ld_hazard = !ex_en_ && (ex_mem_op == MEM_LDW) &&
                     ((ra_used && (ex_dst_addr == ra_addr)) ||
                      (rb_used && (ex_dst_addr == rb_addr)));

  assign br_taken = br_cond && !if_en_ && !ld_hazard;

endmodule

// File: rtl/yutorina_id_stage.sv
// Yutorina decode stage: combinational decode/branch resolve feeding the ID/EX register.
// Ports: fetch inputs, register-file read port, EX/MEM forwarding taps, branch/hazard
// outputs to fetch/controller, and the registered id_* control bundle (1-cycle latency).
module yutorina_id_stage
  import yutorina_id_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [WORD_ADDR_W-1:0] if_pc,
  input  logic [WORD_DATA_W-1:0] if_insn,
  input  logic                   if_en_,
  output logic [REG_ADDR_W-1:0]  gpr_rd_addr_0,
  output logic [REG_ADDR_W-1:0]  gpr_rd_addr_1,
  input  logic [WORD_DATA_W-1:0] gpr_rd_data_0,
  input  logic [WORD_DATA_W-1:0] gpr_rd_data_1,
  input  logic                   ex_en_,
  input  logic                   ex_gpr_we_,
  input  logic [REG_ADDR_W-1:0]  ex_dst_addr,
  input  logic [WORD_DATA_W-1:0] ex_fwd_data,
  input  logic [1:0]             ex_mem_op,
  input  logic                   mem_en_,
  input  logic                   mem_gpr_we_,
  input  logic [REG_ADDR_W-1:0]  mem_dst_addr,
  input  logic [WORD_DATA_W-1:0] mem_fwd_data,
  output logic                   br_taken,
  output logic [WORD_ADDR_W-1:0] br_addr,
  output logic                   ld_hazard,
  output logic [WORD_ADDR_W-1:0] id_pc,
  output logic                   id_en_,
  output logic [3:0]             id_alu_op,
  output logic [WORD_DATA_W-1:0] id_alu_in_0,
  output logic [WORD_DATA_W-1:0] id_alu_in_1,
  output logic                   id_br_flag,
  output logic [1:0]             id_mem_op,
  output logic [WORD_DATA_W-1:0] id_mem_wr_data,
  output logic [REG_ADDR_W-1:0]  id_dst_addr,
  output logic                   id_gpr_we_,
  output logic [2:0]             id_exp_code
);

  ctrl_t dec, id_q;

  yutorina_decoder u_decoder (
    .if_pc         (if_pc),
    .if_insn       (if_insn),
    .if_en_        (if_en_),
    .gpr_rd_addr_0 (gpr_rd_addr_0),
    .gpr_rd_addr_1 (gpr_rd_addr_1),
    .gpr_rd_data_0 (gpr_rd_data_0),
    .gpr_rd_data_1 (gpr_rd_data_1),
    .ex_en_        (ex_en_),
    .ex_gpr_we_    (ex_gpr_we_),
    .ex_dst_addr   (ex_dst_addr),
    .ex_fwd_data   (ex_fwd_data),
    .ex_mem_op     (ex_mem_op),
    .mem_en_       (mem_en_),
    .mem_gpr_we_   (mem_gpr_we_),
    .mem_dst_addr  (mem_dst_addr),
    .mem_fwd_data  (mem_fwd_data),
    .dec           (dec),
    .br_taken      (br_taken),
    .br_addr       (br_addr),
    .ld_hazard     (ld_hazard)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc  <= '0;
      id_en_ <= 1'b1;
      id_q   <= CTRL_RST;
    end else if (stall) begin
      id_pc  <= id_pc;
      id_en_ <= id_en_;
      id_q   <= id_q;
    end else if (flush) begin
      id_pc  <= if_pc;
      id_en_ <= 1'b1;
      id_q   <= CTRL_RST;
    end else if (ld_hazard) begin
      // Bubble: the same instruction comes back once the load has resolved.
      id_pc           <= if_pc;
      id_en_          <= 1'b1;
      id_q            <= dec;
      id_q.gpr_we_    <= 1'b1;
      id_q.mem_op     <= MEM_NOP;
      id_q.exp_code   <= EXP_NONE;
    end else begin
      id_pc  <= if_pc;
      id_en_ <= if_en_;
      id_q   <= dec;
      if (if_en_) begin
        id_q.gpr_we_ <= 1'b1;
        id_q.mem_op  <= MEM_NOP;
      end
    end
  end

  assign id_alu_op      = id_q.alu_op;
  assign id_alu_in_0    = id_q.alu_in_0;
  assign id_alu_in_1    = id_q.alu_in_1;
  assign id_br_flag     = id_q.br_flag;
  assign id_mem_op      = id_q.mem_op;
  assign id_mem_wr_data = id_q.mem_wr_data;
  assign id_dst_addr    = id_q.dst_addr;
  assign id_gpr_we_     = id_q.gpr_we_;
  assign id_exp_code    = id_q.exp_code;

endmodule

// File: tb/tb_yutorina_id_stage.sv
module tb_yutorina_id_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, if_en_;
  logic [29:0] if_pc;
  logic [31:0] if_insn;
  logic [4:0]  gpr_rd_addr_0, gpr_rd_addr_1;
  logic [31:0] gpr_rd_data_0, gpr_rd_data_1;
  logic        ex_en_, ex_gpr_we_, mem_en_, mem_gpr_we_;
  logic [4:0]  ex_dst_addr, mem_dst_addr;
  logic [31:0] ex_fwd_data, mem_fwd_data;
  logic [1:0]  ex_mem_op;
  logic        br_taken, ld_hazard;
  logic [29:0] br_addr, id_pc;
  logic        id_en_, id_br_flag, id_gpr_we_;
  logic [3:0]  id_alu_op;
  logic [31:0] id_alu_in_0, id_alu_in_1, id_mem_wr_data;
  logic [1:0]  id_mem_op;
  logic [4:0]  id_dst_addr;
  logic [2:0]  id_exp_code;

  logic [31:0] regs [32];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign gpr_rd_data_0 = regs[gpr_rd_addr_0];
  assign gpr_rd_data_1 = regs[gpr_rd_addr_1];

  yutorina_id_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_pc(if_pc), .if_insn(if_insn), .if_en_(if_en_),
    .gpr_rd_addr_0(gpr_rd_addr_0), .gpr_rd_addr_1(gpr_rd_addr_1),
    .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
    .ex_en_(ex_en_), .ex_gpr_we_(ex_gpr_we_), .ex_dst_addr(ex_dst_addr),
    .ex_fwd_data(ex_fwd_data), .ex_mem_op(ex_mem_op),
    .mem_en_(mem_en_), .mem_gpr_we_(mem_gpr_we_), .mem_dst_addr(mem_dst_addr),
    .mem_fwd_data(mem_fwd_data),
    .br_taken(br_taken), .br_addr(br_addr), .ld_hazard(ld_hazard),
    .id_pc(id_pc), .id_en_(id_en_), .id_alu_op(id_alu_op),
    .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1), .id_br_flag(id_br_flag),
    .id_mem_op(id_mem_op), .id_mem_wr_data(id_mem_wr_data), .id_dst_addr(id_dst_addr),
    .id_gpr_we_(id_gpr_we_), .id_exp_code(id_exp_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] ra,
                                     input logic [4:0] rb, input logic [15:0] imm);
    return {op, ra, rb, imm};
  endfunction

  task automatic check_addsi_held(input string tag);
    check({tag, "_pc"},  {2'b00, id_pc}, 32'h40);
    check({tag, "_in1"}, id_alu_in_1, 32'hFFFF_FFFF);
    check({tag, "_dst"}, {27'd0, id_dst_addr}, 32'd2);
    check({tag, "_we"},  {31'd0, id_gpr_we_}, 32'd0);
    check({tag, "_exp"}, {29'd0, id_exp_code}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[1] = 32'd5;  regs[3] = 32'h33; regs[4] = 32'h44; regs[7] = 32'd7;
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    if_pc = '0; if_insn = '0; if_en_ = 1'b1;
    ex_en_ = 1'b1; ex_gpr_we_ = 1'b1; ex_dst_addr = '0; ex_fwd_data = '0; ex_mem_op = 2'd0;
    mem_en_ = 1'b1; mem_gpr_we_ = 1'b1; mem_dst_addr = '0; mem_fwd_data = '0;

    // Reset state
    step(); step();
    check("rst_en",  {31'd0, id_en_}, 32'd1);
    check("rst_we",  {31'd0, id_gpr_we_}, 32'd1);
    check("rst_pc",  {2'b00, id_pc}, 32'd0);
    check("rst_alu", {28'd0, id_alu_op}, 32'd0);
    check("rst_mem", {30'd0, id_mem_op}, 32'd0);
    check("rst_exp", {29'd0, id_exp_code}, 32'd0);
    #2 rst = 1'b1;

    // ADDSI r2 <- r1 + sext(0xFFFF)
    if_en_ = 1'b0; if_pc = 30'h10; if_insn = mk(6'h07, 5'd1, 5'd2, 16'hFFFF);
    step();
    check("addsi_in1", id_alu_in_1, 32'hFFFF_FFFF);
    check("addsi_in0", id_alu_in_0, 32'd5);
    check("addsi_dst", {27'd0, id_dst_addr}, 32'd2);
    check("addsi_we",  {31'd0, id_gpr_we_}, 32'd0);
    check("addsi_op",  {28'd0, id_alu_op}, 32'd4);
    check("addsi_pc",  {2'b00, id_pc}, 32'h10);
    check("addsi_en",  {31'd0, id_en_}, 32'd0);

    // BE r7,r7 with negative offset: 0x100 + (-16) = 0xF0
    if_pc = 30'h100; if_insn = mk(6'h10, 5'd7, 5'd7, 16'hFFF0);
    #1;
    check("be_taken", {31'd0, br_taken}, 32'd1);
    check("be_addr",  {2'b00, br_addr}, 32'hF0);
    if_en_ = 1'b1; #1;
    check("be_inv_taken", {31'd0, br_taken}, 32'd0);
    if_en_ = 1'b0; if_insn = mk(6'h11, 5'd7, 5'd7, 16'hFFF0); #1;
    check("bne_taken", {31'd0, br_taken}, 32'd0);
    step();
    check("bne_brflag", {31'd0, id_br_flag}, 32'd1);
    check("bne_we",     {31'd0, id_gpr_we_}, 32'd1);

    // Forwarding on r3: EX beats MEM beats register file
    ex_en_ = 1'b0; ex_gpr_we_ = 1'b0; ex_dst_addr = 5'd3; ex_fwd_data = 32'hAA;
    mem_en_ = 1'b0; mem_gpr_we_ = 1'b0; mem_dst_addr = 5'd3; mem_fwd_data = 32'hBB;
    if_insn = mk(6'h02, 5'd3, 5'd0, 16'h2800);
    step();
    check("fwd_ex",  id_alu_in_0, 32'hAA);
    check("orr_dst", {27'd0, id_dst_addr}, 32'd5);
    check("orr_op",  {28'd0, id_alu_op}, 32'd2);
    ex_en_ = 1'b1;
    step();
    check("fwd_mem", id_alu_in_0, 32'hBB);
    mem_en_ = 1'b1;
    step();
    check("fwd_rf", id_alu_in_0, 32'h33);

    // Load-use against EX LDW r4
    ex_en_ = 1'b0; ex_gpr_we_ = 1'b0; ex_dst_addr = 5'd4; ex_mem_op = 2'd1; ex_fwd_data = 32'h99;
    if_insn = mk(6'h08, 5'd1, 5'd4, 16'h0000);
    #1;
    check("lu_hazard", {31'd0, ld_hazard}, 32'd1);
    step();
    check("lu_en",  {31'd0, id_en_}, 32'd1);
    check("lu_mem", {30'd0, id_mem_op}, 32'd0);
    check("lu_we",  {31'd0, id_gpr_we_}, 32'd1);
    if_insn = mk(6'h09, 5'd1, 5'd4, 16'h0003);
    #1;
    check("lu_imm_hazard", {31'd0, ld_hazard}, 32'd0);
    step();
    check("addui_en",  {31'd0, id_en_}, 32'd0);
    check("addui_we",  {31'd0, id_gpr_we_}, 32'd0);
    check("addui_in1", id_alu_in_1, 32'd3);
    check("addui_in0", id_alu_in_0, 32'd5);
    ex_en_ = 1'b1; ex_mem_op = 2'd0;

    // LDW r6 <- [r1 - 4]
    if_insn = mk(6'h16, 5'd1, 5'd6, 16'hFFFC);
    step();
    check("ldw_in1", id_alu_in_1, 32'hFFFF_FFFC);
    check("ldw_mem", {30'd0, id_mem_op}, 32'd1);
    check("ldw_dst", {27'd0, id_dst_addr}, 32'd6);

    // STW [r1+8] <- r3
    if_insn = mk(6'h17, 5'd1, 5'd3, 16'h0008);
    step();
    check("stw_mem",  {30'd0, id_mem_op}, 32'd2);
    check("stw_data", id_mem_wr_data, 32'h33);
    check("stw_we",   {31'd0, id_gpr_we_}, 32'd1);

    // CALL r7: target 7>>2 = 1, link = 0x200<<2
    if_pc = 30'h200; if_insn = mk(6'h15, 5'd7, 5'd0, 16'h0000);
    #1;
    check("call_taken", {31'd0, br_taken}, 32'd1);
    check("call_addr",  {2'b00, br_addr}, 32'd1);
    step();
    check("call_dst", {27'd0, id_dst_addr}, 32'd31);
    check("call_we",  {31'd0, id_gpr_we_}, 32'd0);
    check("call_in0", id_alu_in_0, 32'h800);

    // Exceptions
    if_insn = mk(6'h3F, 5'd1, 5'd2, 16'h0000);
    step();
    check("undef_exp", {29'd0, id_exp_code}, 32'd1);
    check("undef_we",  {31'd0, id_gpr_we_}, 32'd1);
    if_insn = mk(6'h18, 5'd0, 5'd0, 16'h0000);
    step();
    check("trap_exp", {29'd0, id_exp_code}, 32'd2);

    // Stall holds for 3 cycles while inputs change
    if_pc = 30'h40; if_insn = mk(6'h07, 5'd1, 5'd2, 16'hFFFF);
    step();
    stall = 1'b1; if_pc = 30'h50; if_insn = mk(6'h18, 5'd0, 5'd0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      check_addsi_held("stall");
    end

    // Flush loads reset values but captures if_pc
    stall = 1'b0; flush = 1'b1; if_pc = 30'h77;
    step();
    check("flush_pc",  {2'b00, id_pc}, 32'h77);
    check("flush_en",  {31'd0, id_en_}, 32'd1);
    check("flush_we",  {31'd0, id_gpr_we_}, 32'd1);
    check("flush_in1", id_alu_in_1, 32'd0);
    check("flush_exp", {29'd0, id_exp_code}, 32'd0);
    check("flush_dst", {27'd0, id_dst_addr}, 32'd0);
    flush = 1'b0;

    // Asynchronous reset mid-stall
    if_pc = 30'h40; if_insn = mk(6'h07, 5'd1, 5'd2, 16'hFFFF);
    step();
    stall = 1'b1;
    step();
    check_addsi_held("prerst");
    #2 rst = 1'b0;
    #1;
    check("arst_en",  {31'd0, id_en_}, 32'd1);
    check("arst_pc",  {2'b00, id_pc}, 32'd0);
    check("arst_we",  {31'd0, id_gpr_we_}, 32'd1);
    check("arst_in1", id_alu_in_1, 32'd0);
    #1 rst = 1'b1; stall = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
